// File: rtl/generador_ventana.sv
// 3x3 sliding window generator over a raster grayscale stream, using two line buffers.
// Latency: the window is registered and appears 1 cycle after accepting pixel (x>=2, y>=2).
// No backpressure: each pix_valid pixel is always accepted; idle cycles hold all state.
module generador_ventana #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        sof,
    output logic [71:0] pixeles,
    output logic        win_valid,
    output logic [9:0]  win_x,
    output logic [9:0]  win_y,
    output logic        frame_done
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

    // Line buffers: lb0 holds line y-1, lb1 holds line y-2 (not reset)
    logic [7:0] lb0_mem [IMG_W];
    logic [7:0] lb1_mem [IMG_W];

    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [71:0] win_q, win_d;
    logic [71:0] pixeles_q, pixeles_d;
    logic [9:0]  win_x_q, win_x_d;
    logic [9:0]  win_y_q, win_y_d;
    logic        win_valid_q, win_valid_d;
    logic        frame_done_q, frame_done_d;

    logic [9:0]    cur_x;
    logic [9:0]    cur_y;
    logic [AW-1:0] col;
    logic [7:0]    rd_top;
    logic [7:0]    rd_mid;

    // Position of the pixel being accepted; sof forces (0,0) whatever the counters say
    always_comb begin
        cur_x  = sof ? 10'd0 : x_q;
        cur_y  = sof ? 10'd0 : y_q;
        col    = cur_x[AW-1:0];
        rd_top = lb1_mem[col];
        rd_mid = lb0_mem[col];
    end

    // Next-state: raster counters, window shift and registered window outputs
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        win_d        = win_q;
        pixeles_d    = pixeles_q;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (pix_valid) begin
            if (cur_x == X_LAST) begin
                x_d = 10'd0;
                y_d = (cur_y == Y_LAST) ? 10'd0 : cur_y + 10'd1;
            end else begin
                x_d = cur_x + 10'd1;
                y_d = cur_y;
            end
            // Rows oldest-first, each row shifts left and takes the new column on the right
            win_d = {win_q[63:48], rd_top, win_q[39:24], rd_mid, win_q[15:0], pix_in};
            // Columns 0 and 1 would mix in data from the previous line, so no window there
            if (cur_x >= 10'd2 && cur_y >= 10'd2) begin
                pixeles_d   = win_d;
                win_x_d     = cur_x - 10'd1;
                win_y_d     = cur_y - 10'd1;
                win_valid_d = 1'b1;
            end
            frame_done_d = (cur_x == X_LAST) && (cur_y == Y_LAST);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            win_q        <= '0;
            pixeles_q    <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            win_q        <= win_d;
            pixeles_q    <= pixeles_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer update: line y-1 ages into y-2, current pixel becomes line y-1
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1_mem[col] <= rd_mid;
            lb0_mem[col] <= pix_in;
        end
    end

    assign pixeles    = pixeles_q;
    assign win_valid  = win_valid_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_generador_ventana.sv
module tb_generador_ventana;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        sof;
    logic [71:0] pixeles;
    logic        win_valid;
    logic [9:0]  win_x;
    logic [9:0]  win_y;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    generador_ventana #(.IMG_W(8), .IMG_H(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .pixeles   (pixeles),
        .win_valid (win_valid),
        .win_x     (win_x),
        .win_y     (win_y),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: log every window and frame_done pulse, sampled on the falling edge
    logic [71:0] q_pix[$];
    int          q_x[$];
    int          q_y[$];
    int          fd_cyc[$];
    int          consec = 0;
    int          fd_wv  = 0;
    int          cyc    = 0;
    logic        prev_wv = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (win_valid === 1'b1) begin
            q_pix.push_back(pixeles);
            q_x.push_back(int'(win_x));
            q_y.push_back(int'(win_y));
            if (prev_wv) consec++;
        end
        if (frame_done === 1'b1) begin
            fd_cyc.push_back(cyc);
            if (win_valid === 1'b1) fd_wv++;
        end
        prev_wv = (win_valid === 1'b1);
    end

    // Expected window centred at (x-1, y-1) for last pixel (x,y), pixel value y*16+x
    function automatic logic [71:0] exp_win(input int x, input int y);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w = {w[63:0], 8'((y - 2 + r) * 16 + (x - 2 + c))};
        return w;
    endfunction

    task automatic clear_mon();
        q_pix.delete();
        q_x.delete();
        q_y.delete();
        fd_cyc.delete();
        consec = 0;
        fd_wv  = 0;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        sof       = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pix(input logic [7:0] p, input logic s);
        pix_in    = p;
        sof       = s;
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic send_frame(input int gap, input logic first_sof);
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++) begin
                send_pix(8'(y * 16 + x), first_sof && x == 0 && y == 0);
                if (gap > 0) idle(gap);
            end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = 8'h00;
        #3;
        n_checks++;
        if (pixeles !== 72'h0 || win_valid !== 1'b0 || win_x !== 10'd0 || win_y !== 10'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got pix=%h wv=%b wx=%0d wy=%0d fd=%b, expected all 0", pixeles, win_valid, win_x, win_y, frame_done);
        end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        n_checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || pixeles !== 72'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got wv=%b fd=%b pix=%h, expected 0", win_valid, frame_done, pixeles);
        end
    endtask

    task automatic test_continuous();
        clear_mon();
        send_frame(0, 1'b1);
        idle(3);
        n_checks++;
        if (q_pix.size() !== 24) begin
            n_fail++;
            $display("FAIL cont_count: got %0d windows, expected 24", q_pix.size());
        end
        for (int i = 0; i < q_pix.size() && i < 24; i++) begin
            n_checks++;
            if (q_pix[i] !== exp_win(i % 6 + 2, i / 6 + 2) || q_x[i] !== i % 6 + 1 || q_y[i] !== i / 6 + 1) begin
                n_fail++;
                $display("FAIL cont_win[%0d]: got %h (%0d,%0d), expected %h (%0d,%0d)", i, q_pix[i], q_x[i], q_y[i],
                         exp_win(i % 6 + 2, i / 6 + 2), i % 6 + 1, i / 6 + 1);
            end
        end
        if (q_pix.size() > 0) begin
            n_checks++;
            if (q_pix[0] !== 72'h000102101112202122 || q_x[0] !== 1 || q_y[0] !== 1) begin
                n_fail++;
                $display("FAIL cont_first: got %h (%0d,%0d), expected 000102101112202122 (1,1)", q_pix[0], q_x[0], q_y[0]);
            end
            n_checks++;
            if (q_pix[$] !== 72'h353637454647555657 || q_x[$] !== 6 || q_y[$] !== 4) begin
                n_fail++;
                $display("FAIL cont_last: got %h (%0d,%0d), expected 353637454647555657 (6,4)", q_pix[$], q_x[$], q_y[$]);
            end
        end
        n_checks++;
        if (fd_cyc.size() !== 1 || fd_wv !== 1) begin
            n_fail++;
            $display("FAIL cont_frame_done: got %0d pulses (%0d with win_valid), expected 1 (1)", fd_cyc.size(), fd_wv);
        end
    endtask

    task automatic test_gaps();
        clear_mon();
        send_frame(3, 1'b1);
        idle(3);
        n_checks++;
        if (q_pix.size() !== 24) begin
            n_fail++;
            $display("FAIL gap_count: got %0d windows, expected 24", q_pix.size());
        end
        for (int i = 0; i < q_pix.size() && i < 24; i++) begin
            n_checks++;
            if (q_pix[i] !== exp_win(i % 6 + 2, i / 6 + 2) || q_x[i] !== i % 6 + 1 || q_y[i] !== i / 6 + 1) begin
                n_fail++;
                $display("FAIL gap_win[%0d]: got %h (%0d,%0d), expected %h (%0d,%0d)", i, q_pix[i], q_x[i], q_y[i],
                         exp_win(i % 6 + 2, i / 6 + 2), i % 6 + 1, i / 6 + 1);
            end
        end
        n_checks++;
        if (consec !== 0) begin
            n_fail++;
            $display("FAIL gap_consecutive: got %0d back-to-back win_valid, expected 0", consec);
        end
        n_checks++;
        if (fd_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL gap_frame_done: got %0d pulses, expected 1", fd_cyc.size());
        end
    endtask

    task automatic test_sof_restart();
        int ex_x[$];
        int ey_y[$];
        clear_mon();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                if (y < 3 || x < 4) send_pix(8'(y * 16 + x), x == 0 && y == 0);
        send_frame(0, 1'b1);
        idle(3);
        for (int x = 2; x < 8; x++) begin ex_x.push_back(x); ey_y.push_back(2); end
        for (int x = 2; x < 4; x++) begin ex_x.push_back(x); ey_y.push_back(3); end
        for (int y = 2; y < 6; y++)
            for (int x = 2; x < 8; x++) begin ex_x.push_back(x); ey_y.push_back(y); end
        n_checks++;
        if (q_pix.size() !== 32) begin
            n_fail++;
            $display("FAIL sof_count: got %0d windows, expected 32", q_pix.size());
        end
        for (int i = 0; i < q_pix.size() && i < 32; i++) begin
            n_checks++;
            if (q_pix[i] !== exp_win(ex_x[i], ey_y[i]) || q_x[i] !== ex_x[i] - 1 || q_y[i] !== ey_y[i] - 1) begin
                n_fail++;
                $display("FAIL sof_win[%0d]: got %h (%0d,%0d), expected %h (%0d,%0d)", i, q_pix[i], q_x[i], q_y[i],
                         exp_win(ex_x[i], ey_y[i]), ex_x[i] - 1, ey_y[i] - 1);
            end
        end
        if (q_pix.size() > 8) begin
            n_checks++;
            if (q_pix[8] !== 72'h000102101112202122 || q_x[8] !== 1 || q_y[8] !== 1) begin
                n_fail++;
                $display("FAIL sof_first_new: got %h (%0d,%0d), expected 000102101112202122 (1,1)", q_pix[8], q_x[8], q_y[8]);
            end
        end
        n_checks++;
        if (fd_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL sof_frame_done: got %0d pulses, expected 1", fd_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                if (y < 3 || x < 4) send_pix(8'(y * 16 + x), x == 0 && y == 0);
        n_checks++;
        if (win_valid !== 1'b1 || pixeles !== exp_win(3, 3)) begin
            n_fail++;
            $display("FAIL pre_reset_win: got wv=%b pix=%h, expected 1 %h", win_valid, pixeles, exp_win(3, 3));
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pixeles !== 72'h0 || win_valid !== 1'b0 || win_x !== 10'd0 || win_y !== 10'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got pix=%h wv=%b wx=%0d wy=%0d fd=%b, expected all 0", pixeles, win_valid, win_x, win_y, frame_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        clear_mon();
        send_frame(0, 1'b0);
        idle(3);
        n_checks++;
        if (q_pix.size() !== 24) begin
            n_fail++;
            $display("FAIL rst_count: got %0d windows, expected 24", q_pix.size());
        end
        for (int i = 0; i < q_pix.size() && i < 24; i++) begin
            n_checks++;
            if (q_pix[i] !== exp_win(i % 6 + 2, i / 6 + 2) || q_x[i] !== i % 6 + 1 || q_y[i] !== i / 6 + 1) begin
                n_fail++;
                $display("FAIL rst_win[%0d]: got %h (%0d,%0d), expected %h (%0d,%0d)", i, q_pix[i], q_x[i], q_y[i],
                         exp_win(i % 6 + 2, i / 6 + 2), i % 6 + 1, i / 6 + 1);
            end
        end
        n_checks++;
        if (fd_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL rst_frame_done: got %0d pulses, expected 1", fd_cyc.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(0, 1'b0);
        send_frame(0, 1'b0);
        idle(3);
        n_checks++;
        if (q_pix.size() !== 48) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d windows, expected 48", q_pix.size());
        end
        for (int i = 0; i < q_pix.size() && i < 48; i++) begin
            int k;
            k = i % 24;
            n_checks++;
            if (q_pix[i] !== exp_win(k % 6 + 2, k / 6 + 2) || q_x[i] !== k % 6 + 1 || q_y[i] !== k / 6 + 1) begin
                n_fail++;
                $display("FAIL b2b_win[%0d]: got %h (%0d,%0d), expected %h (%0d,%0d)", i, q_pix[i], q_x[i], q_y[i],
                         exp_win(k % 6 + 2, k / 6 + 2), k % 6 + 1, k / 6 + 1);
            end
        end
        n_checks++;
        if (fd_cyc.size() !== 2 || fd_wv !== 2) begin
            n_fail++;
            $display("FAIL b2b_frame_done: got %0d pulses (%0d with win_valid), expected 2 (2)", fd_cyc.size(), fd_wv);
        end
        if (fd_cyc.size() == 2) begin
            n_checks++;
            if (fd_cyc[1] - fd_cyc[0] !== 48) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d cycles, expected 48", fd_cyc[1] - fd_cyc[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_sof_restart();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/generador_ventana.md
GENERADOR_VENTANA -- requirements
Module: generador_ventana

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per line (3..1024).
REQ-002 SHALL have parameter IMG_H, default 480, meaning lines per frame (3..1024).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning reset; it is asynchronous and active-low.
REQ-005 SHALL have port pix_in, input, 8 bits, meaning unsigned grayscale pixel in raster order.
REQ-006 SHALL have port pix_valid, input, 1 bit, meaning pix_in is accepted this cycle; gaps allowed.
REQ-007 SHALL have port sof, input, 1 bit, meaning the accepted pixel is (x=0, y=0); ignored when pix_valid=0.
REQ-008 SHALL have port pixeles, output, 72 bits, meaning 3x3 window for the convolution input.
REQ-009 SHALL have port win_valid, output, 1 bit, meaning pixeles holds a new complete window this cycle.
REQ-010 SHALL have port win_x, output, 10 bits, meaning column of the window centre.
REQ-011 SHALL have port win_y, output, 10 bits, meaning line of the window centre.
REQ-012 SHALL have port frame_done, output, 1 bit, meaning one-cycle pulse after the last pixel of a frame.

Function
REQ-013 SHALL keep column counter x (0..IMG_W-1) and line counter y (0..IMG_H-1) of the next expected pixel; each accepted pixel advances x, and x wraps to 0 with y+1 after IMG_W-1.
REQ-014 SHALL wrap y from IMG_H-1 to 0 after the last pixel of a frame, so back-to-back frames need no sof.
REQ-015 SHALL treat an accepted pixel with sof=1 as (0,0) regardless of counter state; a partial frame is abandoned without frame_done.
REQ-016 SHALL store the two previous lines in two IMG_W x 8 line buffers, read and written at column x on each accepted pixel.
REQ-017 SHALL shift a 3x3 register each accepted pixel: new right column = {line y-2, line y-1, pix_in} at column x.
REQ-018 SHALL pack pixeles row-major, oldest line first: [71:64]=(x-2,y-2), [63:56]=(x-1,y-2), [55:48]=(x,y-2), [47:40]=(x-2,y-1), [39:32]=(x-1,y-1), [31:24]=(x,y-1), [23:16]=(x-2,y), [15:8]=(x-1,y), [7:0]=(x,y).
REQ-019 SHALL assert win_valid for exactly one cycle, the cycle after accepting pixel (x,y) with x>=2 and y>=2; latency 1 cycle.
REQ-020 SHALL set win_x=x-1 and win_y=y-1 in that same cycle; border pixels produce no window, giving (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-021 SHALL never mix columns across a line boundary; windows at x=0,1 are suppressed even though the shift register holds stale data.
REQ-022 SHALL hold pixeles, win_x, win_y unchanged while win_valid=0.
REQ-023 SHALL pulse frame_done for one cycle, the cycle after accepting pixel (IMG_W-1, IMG_H-1), coincident with the last win_valid.
REQ-024 SHALL take no action on cycles with pix_valid=0; counters, buffers and shift register hold.

Reset
REQ-025 SHALL on rst_n=0 immediately clear x, y, shift register, pixeles, win_x, win_y, win_valid, frame_done to 0; line buffer contents need not be cleared.
REQ-026 SHALL after reset release treat the first accepted pixel as (0,0), with or without sof.
REQ-027 SHALL on reset mid-frame discard the partial frame; no window uses pre-reset line data.

Verification (IMG_W=8, IMG_H=6, pix_in = y*16+x)
REQ-028 Continuous frame, sof on first pixel -> first win_valid after pixel (2,2), pixeles=72'h000102101112202122, win_x=1, win_y=1; exactly 24 win_valid pulses.
REQ-029 Same frame -> last window pixeles=72'h353637454647555657, win_x=6, win_y=4, with frame_done high that cycle only.
REQ-030 Same frame, pix_valid low for 3 cycles after every accepted pixel -> identical 24 windows in identical order, win_valid never two consecutive cycles.
REQ-031 sof asserted again at pixel (4,3) -> that pixel is (0,0); no frame_done for the abandoned frame; next window appears after new pixel (2,2).
REQ-032 rst_n low for one cycle mid-line 3 -> all outputs 0 immediately; next frame produces its first window after pixel (2,2) with correct values.
REQ-033 Two frames back-to-back without sof -> 48 windows, two frame_done pulses 48 pixels apart.
